// File: rtl/cmd_interp_char_parser_if.sv
// cmd_interp_char_parser_if: byte input and operand-sequencing outputs of the command character parser
interface cmd_interp_char_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] digit;
  logic       load1_a;
  logic       load2_a;
  logic       load1_b;
  logic       load2_b;
  logic [1:0] op;
  logic       calc_start;
  logic       clear;
  logic       err;
  logic       busy;
  modport master (
    output rx_data, rx_valid,
    input  digit, load1_a, load2_a, load1_b, load2_b, op, calc_start, clear, err, busy
  );
  modport slave (
    input  rx_data, rx_valid,
    output digit, load1_a, load2_a, load1_b, load2_b, op, calc_start, clear, err, busy
  );
endinterface

// File: rtl/cmd_interp_char_parser.sv
// cmd_interp_char_parser: turns an ASCII command stream into operand load strobes, operator, calc start, clear and error
module cmd_interp_char_parser #(
  parameter int MAX_DIGITS = 3,
  parameter int OVF_LIMIT  = 255
) (
  input logic clk,
  input logic rst,
  cmd_interp_char_parser_if.slave bus
);
  typedef enum logic [2:0] {A_FIRST, A_NEXT, B_FIRST, B_NEXT, ERR} state_t;
  state_t     state_q;
  logic [1:0] cnt_q;
  logic [9:0] shadow_q;
  logic [7:0] digit_q;
  logic [1:0] op_q;
  logic       l1a_q, l2a_q, l1b_q, l2b_q, calc_q, clr_q;
  logic [7:0] c;
  logic [3:0] d;
  logic [1:0] op_code;
  logic [9:0] acc;
  logic       is_dig, is_op, is_term, is_sp, is_clr, ovf;
  assign c = bus.rx_data;
  assign d = c[3:0];
  always_comb begin
    is_dig  = c >= 8'h30 && c <= 8'h39;
    is_op   = c == 8'h2b || c == 8'h2d || c == 8'h2a || c == 8'h2f;
    op_code = c == 8'h2d ? 2'd1 : c == 8'h2a ? 2'd2 : c == 8'h2f ? 2'd3 : 2'd0;
    is_term = c == 8'h3d || c == 8'h0d;
    is_sp   = c == 8'h20;
    is_clr  = c == 8'h43 || c == 8'h63;
    acc     = shadow_q * 10'd10 + {6'd0, d};
    ovf     = 32'(cnt_q) >= MAX_DIGITS || 32'(acc) > OVF_LIMIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= A_FIRST;
      cnt_q    <= '0;
      shadow_q <= '0;
      digit_q  <= '0;
      op_q     <= '0;
      {l1a_q, l2a_q, l1b_q, l2b_q, calc_q, clr_q} <= '0;
    end else begin
      {l1a_q, l2a_q, l1b_q, l2b_q, calc_q, clr_q} <= '0;
      if (bus.rx_valid && is_clr) begin
        clr_q    <= 1'b1;
        op_q     <= '0;
        cnt_q    <= '0;
        shadow_q <= '0;
        state_q  <= A_FIRST;
      end else if (bus.rx_valid && !is_sp) begin
        case (state_q)
          A_FIRST, B_FIRST: begin
            if (is_dig) begin
              l1a_q    <= state_q == A_FIRST;
              l1b_q    <= state_q == B_FIRST;
              digit_q  <= {4'd0, d};
              cnt_q    <= 2'd1;
              shadow_q <= {6'd0, d};
              state_q  <= state_q == A_FIRST ? A_NEXT : B_NEXT;
            end else
              state_q <= ERR;
          end
          A_NEXT, B_NEXT: begin
            if (is_dig && ovf)
              state_q <= ERR;
            else if (is_dig) begin
              l2a_q    <= state_q == A_NEXT;
              l2b_q    <= state_q == B_NEXT;
              digit_q  <= {4'd0, d};
              cnt_q    <= cnt_q + 2'd1;
              shadow_q <= acc;
            end else if (state_q == A_NEXT && is_op) begin
              op_q    <= op_code;
              state_q <= B_FIRST;
            end else if (state_q == B_NEXT && is_term) begin
              calc_q  <= 1'b1;
              state_q <= A_FIRST;
            end else
              state_q <= ERR;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.digit      = digit_q;
  assign bus.load1_a    = l1a_q;
  assign bus.load2_a    = l2a_q;
  assign bus.load1_b    = l1b_q;
  assign bus.load2_b    = l2b_q;
  assign bus.op         = op_q;
  assign bus.calc_start = calc_q;
  assign bus.clear      = clr_q;
  assign bus.err        = state_q == ERR;
  assign bus.busy       = state_q != A_FIRST;
endmodule

// File: tb/tb_cmd_interp_char_parser.sv
// tb_cmd_interp_char_parser: table-driven directed check of the command character parser
module tb_cmd_interp_char_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  cmd_interp_char_parser_if bus ();
  cmd_interp_char_parser #(.MAX_DIGITS(3), .OVF_LIMIT(255)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] ch;
    logic [7:0] f;
    logic [7:0] d;
    logic [1:0] o;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [17:0] act();
    return {bus.load1_a, bus.load2_a, bus.load1_b, bus.load2_b, bus.calc_start, bus.clear,
            bus.err, bus.busy, bus.digit, bus.op};
  endfunction
  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%b digit=%0d op=%0d, expected flags=%b digit=%0d op=%0d",
               nm, got[17:10], got[9:2], got[1:0], exp[17:10], exp[9:2], exp[1:0]);
    end
  endtask
  task automatic add(input logic v, input logic r, input logic [7:0] ch, input logic [7:0] f,
                     input logic [7:0] d, input logic [1:0] o);
    tbl.push_back('{v, r, ch, f, d, o});
  endtask
  task automatic drive(input logic v, input logic r, input logic [7:0] ch);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = ch;
    rst          = r;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    rst          = 1'b0;
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    // "12+7=" with idle cycles
    add(1, 0, "1", 8'b10000001, 8'd1, 2'd0);
    add(0, 0, "x", 8'b00000001, 8'd1, 2'd0);
    add(1, 0, "2", 8'b01000001, 8'd2, 2'd0);
    add(0, 0, "x", 8'b00000001, 8'd2, 2'd0);
    add(1, 0, "+", 8'b00000001, 8'd2, 2'd0);
    add(0, 0, "x", 8'b00000001, 8'd2, 2'd0);
    add(1, 0, "7", 8'b00100001, 8'd7, 2'd0);
    add(0, 0, "x", 8'b00000001, 8'd7, 2'd0);
    add(1, 0, "=", 8'b00001000, 8'd7, 2'd0);
    add(0, 0, "x", 8'b00000000, 8'd7, 2'd0);
    // "255*3" CR
    add(1, 0, "2", 8'b10000001, 8'd2, 2'd0);
    add(1, 0, "5", 8'b01000001, 8'd5, 2'd0);
    add(1, 0, "5", 8'b01000001, 8'd5, 2'd0);
    add(1, 0, "*", 8'b00000001, 8'd5, 2'd2);
    add(1, 0, "3", 8'b00100001, 8'd3, 2'd2);
    add(1, 0, 8'h0d, 8'b00001000, 8'd3, 2'd2);
    // "256" overflow, ignored digit, clear
    add(1, 0, "2", 8'b10000001, 8'd2, 2'd2);
    add(1, 0, "5", 8'b01000001, 8'd5, 2'd2);
    add(1, 0, "6", 8'b00000011, 8'd5, 2'd2);
    add(1, 0, "1", 8'b00000011, 8'd5, 2'd2);
    add(1, 0, "c", 8'b00000100, 8'd5, 2'd0);
    // "1234" digit-count limit
    add(1, 0, "1", 8'b10000001, 8'd1, 2'd0);
    add(1, 0, "2", 8'b01000001, 8'd2, 2'd0);
    add(1, 0, "3", 8'b01000001, 8'd3, 2'd0);
    add(1, 0, "4", 8'b00000011, 8'd3, 2'd0);
    add(1, 0, "C", 8'b00000100, 8'd3, 2'd0);
    // " 4 / 2 =" with spaces
    add(1, 0, " ", 8'b00000000, 8'd3, 2'd0);
    add(1, 0, "4", 8'b10000001, 8'd4, 2'd0);
    add(1, 0, " ", 8'b00000001, 8'd4, 2'd0);
    add(1, 0, "/", 8'b00000001, 8'd4, 2'd3);
    add(1, 0, " ", 8'b00000001, 8'd4, 2'd3);
    add(1, 0, "2", 8'b00100001, 8'd2, 2'd3);
    add(1, 0, " ", 8'b00000001, 8'd2, 2'd3);
    add(1, 0, "=", 8'b00001000, 8'd2, 2'd3);
    // sequence errors
    add(1, 0, "c", 8'b00000100, 8'd2, 2'd0);
    add(1, 0, "+", 8'b00000011, 8'd2, 2'd0);
    add(1, 0, "c", 8'b00000100, 8'd2, 2'd0);
    add(1, 0, "5", 8'b10000001, 8'd5, 2'd0);
    add(1, 0, "=", 8'b00000011, 8'd5, 2'd0);
    add(1, 0, "c", 8'b00000100, 8'd5, 2'd0);
    add(1, 0, "5", 8'b10000001, 8'd5, 2'd0);
    add(1, 0, "+", 8'b00000001, 8'd5, 2'd0);
    add(1, 0, "-", 8'b00000011, 8'd5, 2'd0);
    add(1, 0, "c", 8'b00000100, 8'd5, 2'd0);
    add(1, 0, "x", 8'b00000011, 8'd5, 2'd0);
    add(1, 0, "c", 8'b00000100, 8'd5, 2'd0);
    // operand B value overflow: 300 > 255
    add(1, 0, "9", 8'b10000001, 8'd9, 2'd0);
    add(1, 0, "-", 8'b00000001, 8'd9, 2'd1);
    add(1, 0, "3", 8'b00100001, 8'd3, 2'd1);
    add(1, 0, "0", 8'b00010001, 8'd0, 2'd1);
    add(1, 0, "0", 8'b00000011, 8'd0, 2'd1);
    add(1, 0, "c", 8'b00000100, 8'd0, 2'd0);
    // rst in B_NEXT wins over a valid byte
    add(1, 0, "1", 8'b10000001, 8'd1, 2'd0);
    add(1, 0, "2", 8'b01000001, 8'd2, 2'd0);
    add(1, 0, "+", 8'b00000001, 8'd2, 2'd0);
    add(1, 0, "3", 8'b00100001, 8'd3, 2'd0);
    add(1, 1, "9", 8'b00000000, 8'd0, 2'd0);
    add(1, 0, "9", 8'b10000001, 8'd9, 2'd0);
    add(0, 0, "5", 8'b00000001, 8'd9, 2'd0);
    add(1, 0, "c", 8'b00000100, 8'd9, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", act(), 18'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].ch);
      chk($sformatf("vec%0d '%c'", i, tbl[i].ch), act(), {tbl[i].f, tbl[i].d, tbl[i].o});
    end
    // err is a level: it persists over idle cycles
    drive(1, 0, "=");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00);
      chk($sformatf("err_hold%0d", i), {17'd0, bus.err}, 18'd1);
    end
    drive(1, 0, "c");
    // bounded wait for calc_start, then confirm it lasts one cycle
    drive(1, 0, "8");
    drive(1, 0, "*");
    drive(1, 0, "8");
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = "=";
    @(negedge clk);
    bus.rx_valid = 1'b0;
    begin
      int n = 0;
      while (!bus.calc_start && n < 5) begin
        @(negedge clk);
        n++;
      end
      chk("calc_wait", {17'd0, bus.calc_start}, 18'd1);
      chk("calc_op", {16'd0, bus.op}, 18'd2);
      @(negedge clk);
      chk("calc_width", {16'd0, bus.calc_start, bus.busy}, 18'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmd_interp_char_parser.md
Name: cmd_interp_char_parser

Overview:
- Upstream stage of the command-interpreter operand registers.
- Consumes the ASCII byte stream from the UART receiver, e.g. "12+7=".
- Emits a binary digit plus the load1/load2 strobes that drive the decimal-accumulating operand registers (reg = reg*10 + digit). Also emits the operator code, a calculation-start pulse, clear and error indications.
- Output registers are owned downstream. This block only sequences them.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per operand (1..3).
- OVF_LIMIT, 255, largest operand value allowed. Must match the 8-bit operand registers.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received ASCII byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- digit  out  8  binary digit value 0..9, zero-extended; valid while any load strobe is high
- load1_a  out  1  pulse: load first digit of operand A
- load2_a  out  1  pulse: accumulate next digit into operand A
- load1_b  out  1  pulse: load first digit of operand B
- load2_b  out  1  pulse: accumulate next digit into operand B
- op  out  2  operator code: 0 '+', 1 '-', 2 '*', 3 '/'; held until the next operator or clear
- calc_start  out  1  pulse: operands and op are complete
- clear  out  1  pulse: user clear, or an explicit reset of downstream registers
- err  out  1  level: parse error latched
- busy  out  1  level: high in any state except A_FIRST

Behaviour:
- Reset state: all outputs 0, FSM in A_FIRST, digit counter 0, shadow value 0.
- Registered outputs. A byte with rx_valid=1 in cycle N produces its strobes in cycle N+1.
  - Strobes are exactly one cycle wide.
  - digit changes only when a load strobe is produced.
  - If rx_valid is 0, nothing happens.
- Character classes:
  - Digits: 0x30..0x39.
  - Operators: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F.
  - Terminators: '=' 0x3D, CR 0x0D.
  - Space 0x20 is ignored in every state.
  - Clear: 'C' 0x43 or 'c' 0x63.
  - Anything else is invalid.
- FSM states: A_FIRST, A_NEXT, B_FIRST, B_NEXT, ERR.
  - A_FIRST:
    - digit -> load1_a, counter=1, shadow=d, go to A_NEXT.
    - operator, terminator or invalid -> ERR.
  - A_NEXT:
    - digit -> load2_a, counter+1, shadow=shadow*10+d.
    - operator -> latch op, go to B_FIRST.
    - terminator or invalid -> ERR.
  - B_FIRST: same as A_FIRST, using load1_b; next state B_NEXT. An operator here is an error, so "-" cannot be used as a sign.
  - B_NEXT:
    - digit -> load2_b.
    - terminator -> calc_start, go to A_FIRST.
    - operator or invalid -> ERR.
  - ERR: err=1. Every byte except clear is ignored.
- Overflow: in a NEXT state, if counter==MAX_DIGITS, or shadow*10+d > OVF_LIMIT:
  - no load strobe is produced;
  - go to ERR.
  - Shadow arithmetic uses 10 bits so that 25*10+9 is computed without wrapping.
- Clear byte, in any state:
  - clear pulse, err=0, op=0, counter=0, go to A_FIRST.
  - No load strobes in the same cycle.
- rst during a parse: synchronous return to reset state next edge, regardless of rx_valid. No strobes in that cycle.
- Entering ERR does not pulse clear. Downstream registers keep partial values until a clear byte or rst.
- Invariant: at most one of load1_a/load2_a/load1_b/load2_b/calc_start/clear is high in any cycle.

Test Plan:
- Bytes "12+7=" with one idle cycle each -> load1_a digit=1; load2_a digit=2; op=0; load1_b digit=7; calc_start pulse one cycle after '=' is accepted; busy falls to 0 the same cycle.
- "255*3" then CR -> three A strobes (2,5,5), op=2, load1_b digit=3, calc_start. No err.
- "256" -> load1_a 2 and load2_a 5 are produced. The '6' produces no strobe, and err=1 the cycle after. A following "1" is ignored (no strobes). Then 'c' -> clear pulse, err=0, busy=0.
- "1234" with MAX_DIGITS=3 -> fourth digit gives err=1 and no load2_a. Separately, " 4 / 2 =" with spaces -> spaces ignored, op=3, calc_start asserted.
- Sequence errors: "+" first -> err=1. In a fresh case, "5=" -> err=1, no calc_start. In a fresh case, "5+-" -> err=1 and op stays 0.
- Assert rst while in B_NEXT during "12+3" -> all outputs 0 next cycle, busy=0. A following "9" produces load1_a digit=9.
